ss_sng: RTL and testbench
=========================

Name: ss_sng

Overview:
- Stochastic number generator. Converts an N-bit unsigned binary value into a Bernoulli bitstream with P(1) = VALUE/(2^N-1).
- Sits directly upstream of the stochastic moving-average accumulator and drives its 1-bit IN.
- Uses a maximal-length LFSR and a comparator, so each full period emits an exact, deterministic count of ones.
- Value updates are aligned to LFSR period boundaries, so downstream averaging sees whole periods.

Parameters:
- N, 16: value and LFSR width. Legal values are 8, 16 and 32. Any other value is an elaboration error.
- SEED, 1: LFSR reset state. SEED = 0 is replaced by all-ones.

Ports:
- CLK  input  1  clock, rising edge.
- INIT  input  1  asynchronous active-high reset.
- EN  input  1  advance enable. When low, all state holds.
- VALUE  input  N  binary value to encode.
- LOAD  input  1  one-cycle strobe that captures VALUE.
- SEED_IN  input  N  runtime LFSR seed.
- SEED_LOAD  input  1  one-cycle strobe that reseeds the LFSR and restarts the period.
- OUT  output  1  registered stochastic bit.
- PERIOD_DONE  output  1  one-cycle pulse on the last cycle of each LFSR period.

Behaviour:
- Reset (INIT high, asynchronous): lfsr = SEED (all-ones if SEED = 0), value_reg = 0, pend_val = 0, pend_vld = 0, period_cnt = 0, OUT = 0, PERIOD_DONE = 0.
- LFSR: Fibonacci, shift left, feedback into bit 0. Feedback is the XOR of the tap bits of a maximal-length polynomial:
  - N=8: x^8+x^6+x^5+x^4+1.
  - N=16: x^16+x^15+x^13+x^4+1.
  - N=32: x^32+x^22+x^2+x^1+1.
- LFSR states cover 1..M, where M = 2^N-1. The all-zero state is unreachable.
- Each cycle with EN=1:
  - OUT <= (lfsr <= value_reg), as an unsigned N-bit compare.
  - lfsr advances one step.
  - If period_cnt == M-1: period_cnt <= 0 and PERIOD_DONE <= 1. Otherwise period_cnt increments and PERIOD_DONE <= 0.
- Each cycle with EN=0:
  - OUT <= 0 and PERIOD_DONE <= 0.
  - lfsr and period_cnt hold.
  - pend_vld may still be set by LOAD.
- Latency: OUT reflects the lfsr state present one cycle earlier.
- Exactness: over one full period, the number of OUT ones equals value_reg exactly. VALUE = 0 gives zero ones; VALUE = M gives all ones.
- LOAD:
  - LOAD captures pend_val <= VALUE and pend_vld <= 1.
  - A second LOAD before the boundary overwrites pend_val; the latest value wins.
- Boundary (period_cnt == M-1 with EN=1): if pend_vld, value_reg <= pend_val and pend_vld <= 0.
- LOAD in the same cycle as a boundary: the incoming VALUE bypasses pend_val and goes straight to value_reg. pend_vld is cleared.
- SEED_LOAD:
  - lfsr <= SEED_IN, or all-ones if SEED_IN = 0.
  - period_cnt <= 0 and PERIOD_DONE <= 0.
  - A valid pending value is applied to value_reg immediately.
  - SEED_LOAD takes priority over EN-driven advance in the same cycle.
  - SEED_LOAD together with LOAD: the current VALUE goes directly to value_reg.
- INIT mid-period: everything returns to the reset state at once. No partial pending value survives.
- period_cnt width is N bits. It never reaches M, so no wrap ambiguity exists.

Optional Feature:
- Macro: SS_SNG_PERIOD_SYNC_EN.
- Defined: period-aligned loading as described above, and PERIOD_DONE is driven.
- Undefined:
  - LOAD writes value_reg directly on the next edge; pend_val and pend_vld are removed.
  - PERIOD_DONE is tied to 0 and period_cnt is removed.
  - SEED_LOAD only reseeds the LFSR.
  - OUT uses the new value from the cycle after LOAD.

Test Plan (N=8, SEED=1, M=255, macro defined unless stated):
- INIT, LOAD VALUE=0, then EN=1 for 255 cycles -> zero ones on OUT; exactly one PERIOD_DONE pulse, on cycle 255.
- LOAD VALUE=255, EN for 2 periods -> 255 ones per period; PERIOD_DONE every 255 cycles.
- LOAD VALUE=128, one full period -> exactly 128 ones. Repeat with 1 -> 1 one; with 200 -> 200 ones.
- VALUE=200 active; LOAD VALUE=64 at cycle 100; then LOAD 70 at cycle 150 -> the rest of the period still counts against 200; the next full period counts exactly 70 ones. With the macro undefined: the switch takes effect from the cycle after each LOAD, and PERIOD_DONE stays 0.
- SEED_IN=0 with SEED_LOAD -> lfsr=0xFF; no lockup; 255 distinct states before repeat; period_cnt restarts, so PERIOD_DONE occurs 255 cycles after SEED_LOAD.
- INIT pulsed asynchronously mid-period with pend_vld=1 -> OUT=0 and PERIOD_DONE=0 without a clock edge. After release: value_reg=0, lfsr=1, and the pending value is discarded.

Source files
------------

// File: rtl/ss_sng.sv
// ss_sng: stochastic number generator (maximal-length LFSR + comparator).
// Optional macro SS_SNG_PERIOD_SYNC_EN aligns value updates to LFSR period boundaries.
module ss_sng #(
  parameter int          N    = 16,
  parameter int unsigned SEED = 1
) (
  input  logic         CLK,
  input  logic         INIT,
  input  logic         EN,
  input  logic [N-1:0] VALUE,
  input  logic         LOAD,
  input  logic [N-1:0] SEED_IN,
  input  logic         SEED_LOAD,
  output logic         OUT,
  output logic         PERIOD_DONE
);

  generate
    if (N != 8 && N != 16 && N != 32) begin : g_bad_width
      $error("ss_sng: N must be 8, 16 or 32");
    end
  endgenerate

  // Tap masks: bit (k-1) set for each x^k term of the feedback polynomial.
  localparam logic [31:0]  TAP_MASK_32 = (N == 8)  ? 32'h0000_00B8 :
                                         (N == 16) ? 32'h0000_D008 :
                                                     32'h8020_0003;
  localparam logic [N-1:0] TAP_MASK    = TAP_MASK_32[N-1:0];
  localparam logic [N-1:0] SEED_TRUNC  = SEED[N-1:0];
  localparam logic [N-1:0] RESET_LFSR  = (SEED_TRUNC == '0) ? '1 : SEED_TRUNC;

  logic [N-1:0] lfsr_reg;
  logic [N-1:0] lfsr_next;
  logic [N-1:0] value_reg;
  logic [N-1:0] value_next;
  logic         out_reg;
  logic         out_next;
  logic [N-1:0] tap_bits;
  logic         feedback;
  logic [N-1:0] lfsr_step;
  logic [N-1:0] seed_fixed;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_tap
      assign tap_bits[gi] = lfsr_reg[gi] & TAP_MASK[gi];
    end
  endgenerate

  assign feedback   = ^tap_bits;
  assign lfsr_step  = {lfsr_reg[N-2:0], feedback};
  // A zero seed would lock the LFSR, so it is replaced by all-ones.
  assign seed_fixed = (SEED_IN == '0) ? '1 : SEED_IN;
  assign OUT        = out_reg;

`ifdef SS_SNG_PERIOD_SYNC_EN

  localparam logic [N-1:0] LAST_CNT = {{(N-1){1'b1}}, 1'b0};

  logic [N-1:0] pend_val_reg;
  logic [N-1:0] pend_val_next;
  logic         pend_vld_reg;
  logic         pend_vld_next;
  logic [N-1:0] period_cnt_reg;
  logic [N-1:0] period_cnt_next;
  logic         period_done_reg;
  logic         period_done_next;
  logic         boundary;

  always_comb begin
    lfsr_next        = lfsr_reg;
    value_next       = value_reg;
    out_next         = 1'b0;
    pend_val_next    = pend_val_reg;
    pend_vld_next    = pend_vld_reg;
    period_cnt_next  = period_cnt_reg;
    period_done_next = 1'b0;
    boundary         = 1'b0;

    // A reseed restarts the period, so it counts as a boundary for value updates.
    if (SEED_LOAD) begin
      lfsr_next       = seed_fixed;
      period_cnt_next = '0;
      boundary        = 1'b1;
    end else if (EN) begin
      out_next  = (lfsr_reg <= value_reg);
      lfsr_next = lfsr_step;
      if (period_cnt_reg == LAST_CNT) begin
        period_cnt_next  = '0;
        period_done_next = 1'b1;
        boundary         = 1'b1;
      end else begin
        period_cnt_next = period_cnt_reg + 1'b1;
      end
    end

    if (boundary) begin
      if (LOAD) begin
        value_next = VALUE;
      end else if (pend_vld_reg) begin
        value_next = pend_val_reg;
      end
      pend_vld_next = 1'b0;
    end else if (LOAD) begin
      pend_val_next = VALUE;
      pend_vld_next = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      lfsr_reg        <= RESET_LFSR;
      value_reg       <= '0;
      out_reg         <= 1'b0;
      pend_val_reg    <= '0;
      pend_vld_reg    <= 1'b0;
      period_cnt_reg  <= '0;
      period_done_reg <= 1'b0;
    end else begin
      lfsr_reg        <= lfsr_next;
      value_reg       <= value_next;
      out_reg         <= out_next;
      pend_val_reg    <= pend_val_next;
      pend_vld_reg    <= pend_vld_next;
      period_cnt_reg  <= period_cnt_next;
      period_done_reg <= period_done_next;
    end
  end

  assign PERIOD_DONE = period_done_reg;

`else

  // Without period alignment, LOAD takes effect on the very next edge.
  always_comb begin
    lfsr_next  = lfsr_reg;
    value_next = LOAD ? VALUE : value_reg;
    out_next   = 1'b0;
    if (SEED_LOAD) begin
      lfsr_next = seed_fixed;
    end else if (EN) begin
      out_next  = (lfsr_reg <= value_reg);
      lfsr_next = lfsr_step;
    end
  end

  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      lfsr_reg  <= RESET_LFSR;
      value_reg <= '0;
      out_reg   <= 1'b0;
    end else begin
      lfsr_reg  <= lfsr_next;
      value_reg <= value_next;
      out_reg   <= out_next;
    end
  end

  assign PERIOD_DONE = 1'b0;

`endif

endmodule

// File: tb/tb_ss_sng.sv
// tb_ss_sng: randomized and directed check of ss_sng (N=8, SEED=1) against a behavioural model.
// Follows SS_SNG_PERIOD_SYNC_EN the same way the design does.
module tb_ss_sng;
  localparam int N = 8;
  localparam int M = 255;

  logic         CLK = 1'b0;
  logic         INIT;
  logic         EN;
  logic         LOAD;
  logic         SEED_LOAD;
  logic [N-1:0] VALUE;
  logic [N-1:0] SEED_IN;
  logic         OUT;
  logic         PERIOD_DONE;

  ss_sng #(.N(N), .SEED(1)) dut (
    .CLK         (CLK),
    .INIT        (INIT),
    .EN          (EN),
    .VALUE       (VALUE),
    .LOAD        (LOAD),
    .SEED_IN     (SEED_IN),
    .SEED_LOAD   (SEED_LOAD),
    .OUT         (OUT),
    .PERIOD_DONE (PERIOD_DONE)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Polynomial exponents of x^8+x^6+x^5+x^4+1
  int taps[4] = '{8, 6, 5, 4};

  // Reference model state
  int lfsr_m, value_m, pend_m, cnt_m;
  bit exp_out, exp_done, out_dc;
  int ones_dut, done_dut, ones_exp;

  function automatic int lfsr_adv(input int x);
    int p;
    p = 0;
    foreach (taps[i]) p ^= (x >> (taps[i] - 1)) & 1;
    return ((x << 1) & M) | p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    lfsr_m = 1; value_m = 0; pend_m = -1; cnt_m = 0;
    exp_out = 0; exp_done = 0; out_dc = 0;
  endtask

  task automatic model_update(input bit en, input bit ld, input int val, input bit sl, input int sin);
    out_dc   = 0;
    exp_done = 0;
`ifdef SS_SNG_PERIOD_SYNC_EN
    if (sl) begin
      lfsr_m  = (sin == 0) ? M : sin;
      cnt_m   = 0;
      exp_out = 0;
      out_dc  = 1;
      if (ld) value_m = val;
      else if (pend_m >= 0) value_m = pend_m;
      pend_m = -1;
    end else if (en) begin
      exp_out = (lfsr_m <= value_m);
      lfsr_m  = lfsr_adv(lfsr_m);
      if (cnt_m == M - 1) begin
        cnt_m    = 0;
        exp_done = 1;
        if (ld) value_m = val;
        else if (pend_m >= 0) value_m = pend_m;
        pend_m = -1;
      end else begin
        cnt_m++;
        if (ld) pend_m = val;
      end
    end else begin
      exp_out = 0;
      if (ld) pend_m = val;
    end
`else
    if (sl) begin
      lfsr_m  = (sin == 0) ? M : sin;
      exp_out = 0;
      out_dc  = 1;
    end else if (en) begin
      exp_out = (lfsr_m <= value_m);
      lfsr_m  = lfsr_adv(lfsr_m);
    end else begin
      exp_out = 0;
    end
    if (ld) value_m = val;
`endif
  endtask

  task automatic step(input bit en, input bit ld, input int val, input bit sl, input int sin);
    EN = en; LOAD = ld; VALUE = val[7:0]; SEED_LOAD = sl; SEED_IN = sin[7:0];
    @(posedge CLK);
    model_update(en, ld, val, sl, sin);
    #1;
    if (!out_dc) check("out", OUT, exp_out);
    check("period_done", PERIOD_DONE, exp_done);
    if (OUT === 1'b1) ones_dut++;
    if (PERIOD_DONE === 1'b1) done_dut++;
    if (exp_out) ones_exp++;
  endtask

  task automatic clear_counts();
    ones_dut = 0; done_dut = 0; ones_exp = 0;
  endtask

  // Load a value together with a reseed, then run one whole period with EN high.
  task automatic full_period(input int v, input int sin, input string tag);
    step(0, 1, v, 1, sin);
    clear_counts();
    repeat (M) step(1, 0, 0, 0, 0);
    check({tag, "_ones"}, ones_dut, v);
`ifdef SS_SNG_PERIOD_SYNC_EN
    check({tag, "_done_cnt"}, done_dut, 1);
`else
    check({tag, "_done_cnt"}, done_dut, 0);
`endif
  endtask

  initial begin
    INIT = 1'b1; EN = 0; LOAD = 0; SEED_LOAD = 0; VALUE = '0; SEED_IN = '0;
    model_reset();
    clear_counts();
    #12;
    check("reset_out", OUT, 0);
    check("reset_done", PERIOD_DONE, 0);
    INIT = 1'b0;

    // VALUE=0 from reset: no ones, single PERIOD_DONE on the last cycle
    step(0, 1, 0, 0, 0);
    clear_counts();
    repeat (M) step(1, 0, 0, 0, 0);
    check("zero_ones", ones_dut, 0);
`ifdef SS_SNG_PERIOD_SYNC_EN
    check("zero_done_cnt", done_dut, 1);
`endif

    // VALUE=M for two periods: all ones
    step(0, 1, M, 1, 1);
    clear_counts();
    repeat (2 * M) step(1, 0, 0, 0, 0);
    check("full_ones", ones_dut, 2 * M);
`ifdef SS_SNG_PERIOD_SYNC_EN
    check("full_done_cnt", done_dut, 2);
`endif

    full_period(128, 1, "v128");
    full_period(1, $urandom_range(1, 255), "v1");
    full_period(200, $urandom_range(1, 255), "v200");
    full_period(100, 0, "seed0");
    for (int k = 0; k < 3; k++) full_period($urandom_range(0, 255), $urandom_range(0, 255), "vrand");

    // Mid-period loads: 64 at cycle 100, 70 at cycle 150
    step(0, 1, 200, 1, $urandom_range(1, 255));
    clear_counts();
    for (int i = 1; i <= M; i++) step(1, (i == 100) || (i == 150), (i == 100) ? 64 : 70, 0, 0);
`ifdef SS_SNG_PERIOD_SYNC_EN
    check("midload_ones_p1", ones_dut, 200);
`else
    check("midload_ones_p1", ones_dut, ones_exp);
`endif
    clear_counts();
    repeat (M) step(1, 0, 0, 0, 0);
    check("midload_ones_p2", ones_dut, 70);

    // Asynchronous INIT mid-period with a pending value
    step(0, 1, M, 1, 5);
    repeat (50) step(1, 0, 0, 0, 0);
    step(1, 1, 37, 0, 0);
    check("pre_init_out", OUT, 1);
    #2 INIT = 1'b1;
    #1;
    check("init_async_out", OUT, 0);
    check("init_async_done", PERIOD_DONE, 0);
    #3 INIT = 1'b0;
    model_reset();
    clear_counts();
    repeat (M) step(1, 0, 0, 0, 0);
    check("post_init_ones_p1", ones_dut, 0);
    clear_counts();
    repeat (M) step(1, 0, 0, 0, 0);
    check("post_init_ones_p2", ones_dut, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom_range(0, 255),
           $urandom_range(0, 99) == 0, $urandom_range(0, 255));
    end

    EN = 0; LOAD = 0; SEED_LOAD = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
